rr_arb8: RTL and testbench
==========================

# rr_arb8

Round-robin arbiter for eight sources sharing one 8:1 datapath multiplexer. It sits directly upstream of the mux: its registered `sel` drives the mux select, so one source's data passes through per grant. Grants are held for a whole packet, until the source's `last` beat. A per-grant beat counter forces release after `MaxBurst` beats so no source can starve the others.

## Interface
- `MaxBurst`, default 16: maximum accepted beats per grant; legal range 1..255.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  8  per-source request. While a source is granted, its `req` bit also acts as its beat-valid.
- `last`  in  8  per-source end-of-packet flag, qualified by that source's beat.
- `ready`  in  1  downstream accepts the current beat.
- `sel`  out  3  registered index of the granted source; drives the mux select.
- `gnt`  out  8  registered one-hot grant; zero when no source is granted.
- `valid`  out  1  beat present downstream: `busy & req[sel]`.
- `ack`  out  8  one-hot beat accepted: `gnt & {8{valid & ready}}`.

## Operation
- States:
  - IDLE: `gnt` = 0, `valid` = 0, `ack` = 0; `sel` holds the last granted index.
  - BUSY: `gnt` = one-hot of `sel`.
- Registers: `state`, `ptr`/`sel` (3 bits; `sel` always equals `ptr`), `beats` (8 bits).
- Reset values: `state` = IDLE, `sel` = 7, `gnt` = 0, `beats` = 0. `valid` and `ack` are therefore 0. With `ptr` = 7, source 0 has first priority.
- IDLE to BUSY, when `req` != 0:
  - pick the first set bit scanning `ptr+1, ptr+2, …` modulo 8, wrapping;
  - load `sel`/`ptr` with that index, clear `beats`, move to BUSY.
  - If `req` = 0, stay in IDLE.
- In BUSY, a beat is `valid & ready`. On each beat, `beats` increments.
- BUSY to IDLE occurs at the edge where any of these holds:
  - a beat with `last[sel]` = 1;
  - a beat with `beats + 1 == MaxBurst`;
  - `req[sel]` = 0, i.e. the source abandoned the packet.
- When several release conditions hold together, there is exactly one release; they do not stack.
- Beat counting:
  - `ready` = 0 means no beat: `beats` holds and the grant holds indefinitely.
  - `last` bits of non-granted sources are ignored.
  - `beats` never wraps, because release occurs at `MaxBurst` ≤ 255.
- No re-arbitration happens in the release cycle: there is always one IDLE cycle between grants.
- A source that is the only requester is re-granted after that IDLE cycle, including after a `MaxBurst` release.
- Asserting `reset` mid-packet immediately forces all outputs to their reset values. The in-flight beat is lost, and the source must re-request.

## Timing
- `req` sampled at edge k (state IDLE) gives `gnt`/`sel` valid after edge k: one cycle of grant latency.
- `valid` and `ack` are combinational from `req` and `ready`. `sel` and `gnt` are purely registered and glitch-free for the mux.
- Throughput: one beat per cycle while BUSY and `ready` = 1.
- Handover: final beat in cycle n, IDLE in cycle n+1, next grant visible in cycle n+2.
- Single-beat packets from 8 sources reach 50% link utilisation, which is accepted.

## Structure
- Shared package/include holds:
  - `NSRC` = 8 and `SELW` = 3;
  - state encodings IDLE = 1'b0, BUSY = 1'b1.
  These are shared with the mux and any other 8-way arbitration in the design.
- Sub-module `rr_pick8`: a combinational rotating-priority picker.
  - Inputs: `req[7:0]`, `ptr[2:0]`.
  - Outputs: `idx[2:0]`, `any`.
  - Unit-testable alone.
- Top level holds the FSM, the beat counter and output decode.

## Test plan
- Reset with `req` = 8'hFF, then deassert reset → during reset `gnt` = 0 and `sel` = 7; after the first edge, `gnt` = 8'h01 and `sel` = 0.
- `req` = 8'hFF, `last` = 8'hFF, `ready` = 1 → grants go to sources 0,1,…,7,0, a new one every 2 cycles; each `ack` pulse lasts one cycle.
- `MaxBurst` = 4, only `req[3]`, `last` = 0, `ready` = 1 → 4 acks to source 3, one IDLE cycle, then source 3 is re-granted with `beats` = 0.
- Grant to source 2 with `ready` = 0 for 5 cycles, then a `last` beat → `sel` stays 2 and `ack` = 0 throughout the stall; release follows the single `last` beat.
- Source 5 drops `req` mid-packet while `req[6]` = 1 → IDLE at the next edge, then `gnt` = 8'h40. Separately, assert `reset` mid-packet → `gnt` = 0 and `valid` = 0 immediately, and `sel` returns to 7.
- `MaxBurst` = 2 with `last` on beat 2 → exactly one release and one IDLE cycle; the next grant rotates correctly from `ptr`.

Source files
------------

// File: rtl/rr_arb8_pkg.sv
// Shared constants and types for 8-way arbitration and the 8:1 datapath mux.
package rr_arb8_pkg;

  localparam int NSRC = 8;
  localparam int SELW = 3;

  // Arbiter FSM encoding; also used by the mux control and other 8-way arbiters.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // One-hot decode of a source index.
  function automatic logic [NSRC-1:0] onehot8(input logic [SELW-1:0] idx);
    logic [NSRC-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage : rr_arb8_pkg

// File: rtl/rr_arb8_if.sv
// Request/grant/beat bundle between the eight sources, the arbiter and the mux.
//
// Handshake: while a source is granted, req[sel] is its beat-valid and is
// presented downstream as valid; ready is the downstream accept. A beat
// transfers on any cycle where valid & ready, and ack pulses for the granted
// source in exactly that cycle. last[sel] marks the final beat of the packet
// and is only meaningful on a transferring beat.
interface rr_arb8_if;
  import rr_arb8_pkg::*;

  logic [NSRC-1:0] req;
  logic [NSRC-1:0] last;
  logic            ready;
  logic [SELW-1:0] sel;
  logic [NSRC-1:0] gnt;
  logic            valid;
  logic [NSRC-1:0] ack;

  // Arbiter side.
  modport master (
    input  req,
    input  last,
    input  ready,
    output sel,
    output gnt,
    output valid,
    output ack
  );

  // Sources / downstream side.
  modport slave (
    output req,
    output last,
    output ready,
    input  sel,
    input  gnt,
    input  valid,
    input  ack
  );

endinterface : rr_arb8_if

// File: rtl/rr_arb8_pick.sv
// Rotating-priority picker: first set request scanning ptr+1, ptr+2, ...
// modulo 8, so the source at ptr has the lowest priority.
module rr_pick8
  import rr_arb8_pkg::*;
(
  input  logic [NSRC-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] idx,
  output logic            any
);

  logic [SELW-1:0] cand;
  logic            found;

  // Scan eight positions after ptr; the eighth offset wraps back onto ptr.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NSRC; i++) begin
      cand = ptr + SELW'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    any = |req;
  end

endmodule : rr_pick8

// File: rtl/rr_arb8.sv
// Round-robin arbiter for eight packet sources feeding one 8:1 mux.
// A grant is held for a whole packet, released on the last beat, on a
// MaxBurst-beat limit, or when the source drops its request. One IDLE
// cycle always separates consecutive grants.
module rr_arb8
  import rr_arb8_pkg::*;
#(
  parameter int MaxBurst = 16  // 1..255 beats per grant
) (
  input  logic       clk,
  input  logic       reset,
  rr_arb8_if.master  bus,
  output state_t     dbg_state,
  output logic [7:0] dbg_beats
);

  state_t          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [7:0]      beats_q, beats_d;
  logic [NSRC-1:0] gnt_q, gnt_d;

  logic [SELW-1:0] pick_idx;
  logic            pick_any;
  logic            busy;
  logic            beat;
  logic            burst_done;
  logic            release_now;

  rr_pick8 u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign busy       = (state_q == BUSY);
  assign bus.valid  = busy & bus.req[ptr_q];
  assign beat       = bus.valid & bus.ready;
  assign bus.ack    = gnt_q & {NSRC{beat}};
  assign bus.sel    = ptr_q;
  assign bus.gnt    = gnt_q;
  assign burst_done = ((beats_q + 8'd1) == 8'(MaxBurst));

  // Any one release condition ends the grant; overlapping conditions give one release.
  assign release_now = (beat & (bus.last[ptr_q] | burst_done)) | ~bus.req[ptr_q];

  // Next-state, pointer, beat counter and next grant.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    beats_d = beats_q;
    gnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BUSY;
          ptr_d   = pick_idx;
          beats_d = 8'd0;
        end
      end
      BUSY: begin
        if (beat) begin
          beats_d = beats_q + 8'd1;
        end
        if (release_now) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == BUSY) begin
      gnt_d = onehot8(ptr_d);
    end
  end

  // State registers; sel/gnt come straight from flops so the mux select is glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= SELW'(NSRC - 1);
      beats_q <= 8'd0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      beats_q <= beats_d;
      gnt_q   <= gnt_d;
    end
  end

  assign dbg_state = state_q;
  assign dbg_beats = beats_q;

  // Grant is one-hot of sel while busy and zero while idle.
  a_gnt_decode: assert property (@(posedge clk) disable iff (reset)
    gnt_q == (busy ? onehot8(ptr_q) : '0));

  // The beat counter never reaches MaxBurst while a grant is held.
  a_beats_bound: assert property (@(posedge clk) disable iff (reset)
    busy |-> (32'(beats_q) < MaxBurst));

endmodule : rr_arb8

// File: tb/tb_rr_arb8.sv
// Bench for rr_arb8 with MaxBurst = 4: directed scenarios plus random traffic,
// checked cycle by cycle against a reference model through an expected queue.
module tb_rr_arb8;
  import rr_arb8_pkg::*;

  localparam int MB = 4;

  logic       clk;
  logic       reset;
  state_t     dbg_state;
  logic [7:0] dbg_beats;

  rr_arb8_if bus ();

  rr_arb8 #(.MaxBurst(MB)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_beats (dbg_beats)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [19:0] exp_q[$];  // {gnt, sel, valid, ack}

  // reference model
  bit m_busy;
  int m_ptr;
  int m_beats;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_ptr   = 7;
    m_beats = 0;
  endtask

  function automatic logic [19:0] model_outputs();
    logic [7:0] g;
    logic       v;
    logic [7:0] a;
    g = m_busy ? (8'h01 << m_ptr) : 8'h00;
    v = m_busy && bus.req[m_ptr];
    a = (v && bus.ready) ? g : 8'h00;
    return {g, 3'(m_ptr), v, a};
  endfunction

  // Advance the model by one rising edge using the inputs held across it.
  task automatic model_edge();
    bit b;
    if (!m_busy) begin
      for (int k = 1; k <= 8; k++) begin
        int c;
        c = (m_ptr + k) % 8;
        if (bus.req[c]) begin
          m_ptr   = c;
          m_beats = 0;
          m_busy  = 1'b1;
          break;
        end
      end
    end else begin
      b = bus.req[m_ptr] && bus.ready;
      if (!bus.req[m_ptr]) begin
        m_busy = 1'b0;
      end else if (b) begin
        m_beats++;
        if (bus.last[m_ptr] || m_beats == MB) m_busy = 1'b0;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge with inputs already set: predict, sample, clock.
  task automatic cycle();
    logic [19:0] e;
    exp_q.push_back(model_outputs());
    #1;
    e = exp_q.pop_front();
    check("gnt",   bus.gnt,   e[19:12]);
    check("sel",   bus.sel,   e[11:9]);
    check("valid", bus.valid, e[8]);
    check("ack",   bus.ack,   e[7:0]);
    check("state", dbg_state, m_busy);
    if (m_busy) check("beats", dbg_beats, m_beats);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] r, input logic [7:0] l, input logic rd);
    bus.req   = r;
    bus.last  = l;
    bus.ready = rd;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    reset = 1'b1;
    drive(8'hFF, 8'hFF, 1'b1);
    @(negedge clk);
    #1;
    check("rst_gnt",   bus.gnt,   8'h00);
    check("rst_sel",   bus.sel,   3'd7);
    check("rst_valid", bus.valid, 1'b0);
    check("rst_ack",   bus.ack,   8'h00);
    @(negedge clk);
    reset = 1'b0;

    // All sources, single-beat packets: grants 0..7,0 every two cycles.
    cycle();
    check("first_gnt", bus.gnt, 8'h01);
    check("first_sel", bus.sel, 3'd0);
    run(17);
    check("wrap_sel", bus.sel, 3'd0);
    drive(8'h00, 8'h00, 1'b1);
    run(2);

    // Lone requester with no last: MaxBurst release and immediate re-grant.
    drive(8'h08, 8'h00, 1'b1);
    run(14);
    drive(8'h00, 8'h00, 1'b1);
    run(2);

    // Stall on source 2, then a single last beat.
    drive(8'h04, 8'h00, 1'b0);
    run(6);
    check("stall_sel", bus.sel, 3'd2);
    drive(8'h04, 8'h04, 1'b1);
    run(1);
    drive(8'h00, 8'h00, 1'b1);
    run(2);

    // Source 5 abandons mid-packet with source 6 waiting.
    drive(8'h60, 8'h00, 1'b1);
    run(3);
    drive(8'h40, 8'h00, 1'b1);
    run(2);
    check("handover_gnt", bus.gnt, 8'h40);
    drive(8'h00, 8'h00, 1'b1);
    run(2);

    // Asynchronous reset mid-packet.
    drive(8'h01, 8'h00, 1'b0);
    run(3);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_gnt",   bus.gnt,   8'h00);
    check("mid_rst_valid", bus.valid, 1'b0);
    check("mid_rst_sel",   bus.sel,   3'd7);
    check("mid_rst_ack",   bus.ack,   8'h00);
    model_reset();
    @(negedge clk);
    drive(8'h00, 8'h00, 1'b1);
    reset = 1'b0;
    run(2);

    // last coincides with the MaxBurst beat: one release, then rotation from ptr=4.
    drive(8'h10, 8'h00, 1'b1);
    run(4);
    drive(8'h10, 8'h10, 1'b1);
    run(1);
    drive(8'h30, 8'h00, 1'b1);
    run(2);
    check("rotate_gnt", bus.gnt, 8'h20);
    drive(8'h00, 8'h00, 1'b1);
    run(2);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 3) != 0));
      cycle();
    end

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rr_arb8
